mult_div_ctrl: RTL and testbench

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/md_watchdog.sv | 33 +++
 rtl/mult_div_ctrl.sv | 152 +++++++++++++++
 tb/tb_mult_div_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared types and constants for the multiply/divide controller.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } md_state_t;

  localparam logic       MD_OP_MULT        = 1'b0;
  localparam logic       MD_OP_DIV         = 1'b1;
  localparam logic [5:0] MD_TIMEOUT_CYCLES = 6'd48;

endpackage
`default_nettype wire

// File: rtl/md_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : md_watchdog
// Purpose  : WAIT-state cycle counter; flags expiry on the LIMIT-th WAIT cycle.
// Revision : 1.0 - initial release
// ============================================================================
module md_watchdog
  import cpu_pkg::*;
#(
  parameter logic [5:0] LIMIT = MD_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [5:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= 6'd0;
    end else if (i_enable) begin
      r_count <= r_count + 6'd1;
    end
  end

  // Flag in the cycle whose increment would make the count reach LIMIT.
  assign o_expired = i_enable && (r_count == LIMIT - 6'd1);

endmodule
`default_nettype wire

// File: rtl/mult_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_ctrl
// Purpose  : Sequences one multiply or divide operation and the HI/LO write.
//            Optional WAIT watchdog and Timeout port under MD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_ctrl
  import cpu_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic Req,
  input  logic Op,
  input  logic Abort,
  input  logic DivZero,
  input  logic MultOut,
  input  logic DivOut,
  output logic MultIn,
  output logic DivIn,
  output logic ResetMult,
  output logic ResetDiv,
  output logic HighCtrl,
  output logic LowCtrl,
  output logic SetHigh,
  output logic SetLow,
  output logic Busy,
  output logic Done,
  output logic DivZeroExc
`ifdef MD_TIMEOUT_EN
  ,
  output logic Timeout
`endif
);

  md_state_t r_state;
  logic      r_multIn;
  logic      r_divIn;
  logic      r_unitRst;
  logic      r_highCtrl;
  logic      r_lowCtrl;
  logic      r_write;
  logic      r_busy;
  logic      r_divZeroExc;
  logic      w_unitDone;
  logic      w_expired;

  assign w_unitDone = (r_highCtrl == MD_OP_DIV) ? DivOut : MultOut;

`ifdef MD_TIMEOUT_EN
  logic r_timeout;

  md_watchdog #(
    .LIMIT (MD_TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (Clock),
    .rst       (~Reset),
    .i_clear   (r_state == START),
    .i_enable  (r_state == WAIT),
    .o_expired (w_expired)
  );

  assign Timeout = r_timeout;
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state      <= IDLE;
      r_multIn     <= 1'b0;
      r_divIn      <= 1'b0;
      r_unitRst    <= 1'b0;
      r_highCtrl   <= 1'b0;
      r_lowCtrl    <= 1'b0;
      r_write      <= 1'b0;
      r_busy       <= 1'b0;
      r_divZeroExc <= 1'b0;
`ifdef MD_TIMEOUT_EN
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_multIn     <= 1'b0;
      r_divIn      <= 1'b0;
      r_unitRst    <= 1'b0;
      r_write      <= 1'b0;
      r_divZeroExc <= 1'b0;
`ifdef MD_TIMEOUT_EN
      r_timeout    <= 1'b0;
`endif
      // Abort flushes any active operation and resets both arithmetic units.
      if (r_state != IDLE && Abort) begin
        r_state   <= IDLE;
        r_busy    <= 1'b0;
        r_unitRst <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (Req && !Abort) begin
              r_highCtrl <= Op;
              r_lowCtrl  <= Op;
              r_busy     <= 1'b1;
              r_state    <= START;
            end
          end
          START: begin
            if (r_highCtrl == MD_OP_DIV && DivZero) begin
              r_divZeroExc <= 1'b1;
              r_state      <= ERR;
            end else begin
              r_multIn <= (r_highCtrl == MD_OP_MULT);
              r_divIn  <= (r_highCtrl == MD_OP_DIV);
              r_state  <= WAIT;
            end
          end
          WAIT: begin
            if (w_unitDone) begin
              r_write <= 1'b1;
              r_state <= WRITE;
            end else if (w_expired) begin
              r_unitRst <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
`ifdef MD_TIMEOUT_EN
              r_timeout <= 1'b1;
`endif
            end
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  // Same-cycle Abort masks completion pulses that are already registered.
  assign SetHigh    = r_write & ~Abort;
  assign SetLow     = r_write & ~Abort;
  assign Done       = r_write & ~Abort;
  assign DivZeroExc = r_divZeroExc & ~Abort;
  assign ResetMult  = r_unitRst | ~Reset;
  assign ResetDiv   = r_unitRst | ~Reset;
  assign MultIn     = r_multIn;
  assign DivIn      = r_divIn;
  assign HighCtrl   = r_highCtrl;
  assign LowCtrl    = r_lowCtrl;
  assign Busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_ctrl
// Purpose  : Self-checking bench for mult_div_ctrl using a transaction timeline
//            model; the Timeout scenario is built only under MD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_ctrl;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic Req = 1'b0, Op = 1'b0, Abort = 1'b0, DivZero = 1'b0;
  logic MultOut = 1'b0, DivOut = 1'b0;
  logic MultIn, DivIn, ResetMult, ResetDiv, HighCtrl, LowCtrl;
  logic SetHigh, SetLow, Busy, Done, DivZeroExc;
`ifdef MD_TIMEOUT_EN
  logic Timeout;
`endif

  int   checks   = 0;
  int   failures = 0;
  logic prevOp   = 1'b0;

  mult_div_ctrl dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Req        (Req),
    .Op         (Op),
    .Abort      (Abort),
    .DivZero    (DivZero),
    .MultOut    (MultOut),
    .DivOut     (DivOut),
    .MultIn     (MultIn),
    .DivIn      (DivIn),
    .ResetMult  (ResetMult),
    .ResetDiv   (ResetDiv),
    .HighCtrl   (HighCtrl),
    .LowCtrl    (LowCtrl),
    .SetHigh    (SetHigh),
    .SetLow     (SetLow),
    .Busy       (Busy),
    .Done       (Done),
    .DivZeroExc (DivZeroExc)
`ifdef MD_TIMEOUT_EN
    ,
    .Timeout    (Timeout)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int cyc, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkAll(input int t, input logic eBusy, input logic eMultIn,
                          input logic eDivIn, input logic eWrite, input logic eDz,
                          input logic eUnitRst, input logic eHc);
    check("Busy", t, Busy, eBusy);
    check("MultIn", t, MultIn, eMultIn);
    check("DivIn", t, DivIn, eDivIn);
    check("SetHigh", t, SetHigh, eWrite);
    check("SetLow", t, SetLow, eWrite);
    check("Done", t, Done, eWrite);
    check("DivZeroExc", t, DivZeroExc, eDz);
    check("ResetMult", t, ResetMult, eUnitRst);
    check("ResetDiv", t, ResetDiv, eUnitRst);
    check("HighCtrl", t, HighCtrl, eHc);
    check("LowCtrl", t, LowCtrl, eHc);
`ifdef MD_TIMEOUT_EN
    check("Timeout", t, Timeout, 1'b0);
`endif
  endtask

  // One request issued in the current cycle (t=0). Timeline from the rules:
  // start pulse at t=2, unit done at t=2+lat, write at t=3+lat.
  // abortAt: -1 none, 0 abort alongside the Req in IDLE, >0 abort cycle.
  // resetAt: -1 none, >0 cycle in which Reset is driven low.
  task automatic runTxn(input logic op, input int lat, input logic dz0,
                        input int abortAt, input int resetAt);
    logic dz;
    logic active;
    logic eHc;
    int   writeT;
    int   idleT;
    int   reqAgainT;
    dz     = op & dz0;
    writeT = 3 + lat;
    if (resetAt > 0)      idleT = resetAt + 1;
    else if (abortAt > 0) idleT = abortAt + 1;
    else if (abortAt == 0) idleT = 1;
    else                  idleT = dz ? 3 : 4 + lat;
    reqAgainT = (idleT > 1) ? int'($urandom_range(idleT - 1, 1)) : -1;
    for (int t = 0; t <= idleT; t++) begin
      if (t > 0) begin
        @(posedge Clock);
        #1;
      end
      Req     = (t == 0) || (t == reqAgainT && t != idleT);
      Op      = (t == 0) ? op : 1'($urandom);
      Abort   = (t == abortAt);
      Reset   = !(t == resetAt);
      DivZero = op ? dz0 : 1'($urandom);
      MultOut = op ? 1'($urandom) : (t == 2 + lat);
      DivOut  = op ? (t == 2 + lat) : 1'($urandom);
      #1;
      if (t > 0) begin
        active = (abortAt != 0) && (t < idleT);
        eHc    = (resetAt > 0 && t == idleT) ? 1'b0 : ((abortAt == 0) ? prevOp : op);
        checkAll(t, active,
                 active && !dz && !op && t == 2,
                 active && !dz && op && t == 2,
                 active && !dz && t == writeT && t != abortAt,
                 active && dz && t == 2 && t != abortAt,
                 (abortAt > 0 && t == abortAt + 1) || (t == resetAt),
                 eHc);
      end
    end
    Req   = 1'b0;
    Abort = 1'b0;
    if (resetAt > 0)       prevOp = 1'b0;
    else if (abortAt != 0) prevOp = op;
  endtask

  initial begin
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    checkAll(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    checkAll(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    runTxn(1'b0, 5, 1'b0, -1, -1);   // multiply, unit returns 5 cycles after MultIn
    runTxn(1'b1, 32, 1'b0, -1, -1);  // divide, 32-cycle unit
    runTxn(1'b1, 4, 1'b1, -1, -1);   // divide by zero
    runTxn(1'b0, 3, 1'b0, 5, -1);    // abort 3 cycles into WAIT, same cycle as MultOut
    runTxn(1'b1, 3, 1'b0, -1, -1);   // accepted in the cycle right after the abort
    runTxn(1'b1, 3, 1'b0, 0, -1);    // abort in IDLE drops the Req
    runTxn(1'b0, 6, 1'b0, -1, 4);    // reset during WAIT
    runTxn(1'b1, 3, 1'b1, 1, -1);    // abort beats DivZero in START
    runTxn(1'b0, 2, 1'b0, 5, -1);    // abort in WRITE masks the write pulses
    runTxn(1'b1, 2, 1'b1, 2, -1);    // abort in ERR masks DivZeroExc

    for (int i = 0; i < 24; i++) begin
      logic op;
      logic dz0;
      int   lat;
      int   mode;
      int   normalIdle;
      op   = 1'($urandom);
      dz0  = ($urandom_range(3, 0) == 0);
      lat  = $urandom_range(12, 2);
      mode = $urandom_range(3, 0);
      normalIdle = (op && dz0) ? 3 : 4 + lat;
      case (mode)
        1:       runTxn(op, lat, dz0, $urandom_range(normalIdle - 1, 1), -1);
        2:       if (!(op && dz0)) runTxn(op, lat, dz0, -1, $urandom_range(1 + lat, 3));
                 else runTxn(op, lat, dz0, -1, -1);
        3:       runTxn(op, lat, dz0, 0, -1);
        default: runTxn(op, lat, dz0, -1, -1);
      endcase
    end

`ifdef MD_TIMEOUT_EN
    // Unit never answers: 48 WAIT cycles (t=2..49), Timeout at t=50.
    for (int t = 0; t <= 50; t++) begin
      if (t > 0) begin
        @(posedge Clock);
        #1;
      end
      Req     = (t == 0);
      Op      = 1'b0;
      MultOut = 1'b0;
      DivOut  = 1'b0;
      #1;
      if (t > 0) begin
        check("WdBusy", t, Busy, t < 50);
        check("WdMultIn", t, MultIn, t == 2);
        check("WdTimeout", t, Timeout, t == 50);
        check("WdResetMult", t, ResetMult, t == 50);
        check("WdResetDiv", t, ResetDiv, t == 50);
        check("WdDone", t, Done, 1'b0);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
